// File: rtl/hls_run_sequencer_if.sv
// Host command/response bus for hls_run_sequencer: command handshake out, one-cycle response pulse back.
interface hls_run_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              rsp_valid;
    logic [7:0]        rsp_data;
    logic [1:0]        rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/hls_run_sequencer.sv
// Host-driven sequencer for one Bambu HLS kernel: memory preload/readback, start/done cycle count.
// Optional watchdog enabled by defining HLS_RUN_TIMEOUT_EN.
module hls_run_sequencer #(
    parameter int ADDR_W         = 7,
    parameter int CYC_W          = 32,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                  clock,
    input  logic                  reset,
    hls_run_sequencer_if.slave    host,
    output logic [CYC_W-1:0]      run_cycles,
    output logic                  kern_reset_n,
    output logic                  start_port,
    input  logic                  done_port,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [15:0]           S_Wdata_ram,
    output logic [7:0]            S_data_ram_size,
    input  logic [15:0]           Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    typedef enum logic [2:0] {
        KRST, IDLE, MEM_STB, MEM_WAIT, START, RUN, RESP
    } state_t;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_RUN = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DONE    = 2'b01;

    state_t            r_state;
    logic              r_krst_cnt;
    logic              r_kern_reset_n;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [7:0]        r_rsp_data;
    logic [1:0]        r_rsp_status;
    logic [CYC_W-1:0]  r_run_cycles;
    logic [CYC_W-1:0]  r_cnt;
    logic              r_start;
    logic              r_oe;
    logic              r_we;
    logic              r_is_read;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [3:0]        r_size;
    logic              r_timeout;

    logic [CYC_W-1:0]  w_cnt_next;
    logic              w_hit_limit;
    logic              w_accept;

    // Counter saturates rather than wrapping so a hung kernel never reports a short run.
    assign w_cnt_next = (r_cnt == {CYC_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_accept   = host.cmd_valid && r_cmd_ready;

`ifdef HLS_RUN_TIMEOUT_EN
    localparam logic [CYC_W-1:0] LP_LIMIT  = CYC_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]       ST_TMO    = 2'b10;
    assign w_hit_limit = (r_cnt == LP_LIMIT);
    logic w_unused;
    assign w_unused = ^{Sout_Rdata_ram[15:8], Sout_DataRdy[1]};
`else
    assign w_hit_limit = 1'b0;
    logic w_unused;
    assign w_unused = ^{Sout_Rdata_ram[15:8], Sout_DataRdy[1], CYC_W'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= KRST;
            r_krst_cnt     <= 1'b0;
            r_kern_reset_n <= 1'b0;
            r_cmd_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= 8'h00;
            r_rsp_status   <= 2'b00;
            r_run_cycles   <= '0;
            r_cnt          <= '0;
            r_start        <= 1'b0;
            r_oe           <= 1'b0;
            r_we           <= 1'b0;
            r_is_read      <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= 8'h00;
            r_size         <= 4'h0;
            r_timeout      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_start     <= 1'b0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            case (r_state)
                KRST: begin
                    if (r_krst_cnt) begin
                        r_krst_cnt     <= 1'b0;
                        r_kern_reset_n <= 1'b1;
                        r_cmd_ready    <= 1'b1;
                        r_state        <= IDLE;
                    end else begin
                        r_krst_cnt <= 1'b1;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        case (host.cmd_op)
                            OP_WR, OP_RD: begin
                                r_we      <= (host.cmd_op == OP_WR);
                                r_oe      <= (host.cmd_op == OP_RD);
                                r_is_read <= (host.cmd_op == OP_RD);
                                r_addr    <= host.cmd_addr;
                                r_wdata   <= (host.cmd_op == OP_WR) ? host.cmd_wdata : 8'h00;
                                r_size    <= 4'd8;
                                r_state   <= MEM_STB;
                            end
                            OP_RUN: begin
                                r_start <= 1'b1;
                                r_cnt   <= {{(CYC_W-1){1'b0}}, 1'b1};
                                r_state <= START;
                            end
                            default: begin
                                r_rsp_valid  <= 1'b1;
                                r_rsp_data   <= 8'h00;
                                r_rsp_status <= ST_OK;
                                r_state      <= RESP;
                            end
                        endcase
                    end
                end
                MEM_STB, MEM_WAIT: begin
                    // DataRdy in the strobe cycle itself is honoured, giving 2-cycle minimum latency.
                    if (Sout_DataRdy[0]) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= r_is_read ? Sout_Rdata_ram[7:0] : 8'h00;
                        r_rsp_status <= ST_OK;
                        r_state      <= RESP;
                    end else begin
                        r_state <= MEM_WAIT;
                    end
                end
                START, RUN: begin
                    if (done_port) begin
                        r_run_cycles <= r_cnt;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= 8'h00;
                        r_rsp_status <= ST_DONE;
                        r_state      <= RESP;
                    end else if (w_hit_limit) begin
`ifdef HLS_RUN_TIMEOUT_EN
                        r_run_cycles <= LP_LIMIT;
                        r_rsp_status <= ST_TMO;
`endif
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= 8'h00;
                        r_timeout    <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt   <= w_cnt_next;
                        r_state <= RUN;
                    end
                end
                RESP: begin
                    r_addr  <= '0;
                    r_wdata <= 8'h00;
                    r_size  <= 4'h0;
                    // A timed-out kernel is presumed hung, so it gets a fresh reset pulse.
                    if (r_timeout) begin
                        r_timeout      <= 1'b0;
                        r_kern_reset_n <= 1'b0;
                        r_krst_cnt     <= 1'b0;
                        r_state        <= KRST;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_kern_reset_n <= 1'b0;
                    r_krst_cnt     <= 1'b0;
                    r_cmd_ready    <= 1'b0;
                    r_state        <= KRST;
                end
            endcase
        end
    end

    assign host.cmd_ready  = r_cmd_ready;
    assign host.rsp_valid  = r_rsp_valid;
    assign host.rsp_data   = r_rsp_data;
    assign host.rsp_status = r_rsp_status;

    assign run_cycles      = r_run_cycles;
    assign kern_reset_n    = r_kern_reset_n;
    assign start_port      = r_start;
    assign S_oe_ram        = {1'b0, r_oe};
    assign S_we_ram        = {1'b0, r_we};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, r_addr};
    assign S_Wdata_ram     = {8'h00, r_wdata};
    assign S_data_ram_size = {4'h0, r_size};

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Directed bench for hls_run_sequencer: vector table of host commands plus reset/watchdog sequences.
module tb_hls_run_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] run_cycles;
    logic        kern_reset_n;
    logic        start_port;
    logic        done_port;
    logic [1:0]  S_oe_ram, S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;

    int n_cmp  = 0;
    int n_fail = 0;

    hls_run_sequencer_if #(.ADDR_W(7)) host();

    hls_run_sequencer #(.ADDR_W(7), .CYC_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .host(host),
        .run_cycles(run_cycles), .kern_reset_n(kern_reset_n),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // dly: DataRdy offset from strobe cycle (mem ops) or done cycle k counting start (run, 0 = never)
    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          dly;
        logic [7:0]  exp_data;
        logic [1:0]  exp_status;
        logic [31:0] exp_cycles;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (host.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("cmd_ready_wait", {31'b0, host.cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(input vec_t v);
        int lat = 0;
        wait_ready();
        host.cmd_valid = 1'b1;
        host.cmd_op    = v.op;
        host.cmd_addr  = v.addr;
        host.cmd_wdata = v.wdata;
        Sout_Rdata_ram = {8'h5A, v.rdata};
        @(posedge clock);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == 1) begin
                host.cmd_valid = 1'b0;
                if (v.op == 2'b00 || v.op == 2'b01) begin
                    chk("strobe_we", {30'b0, S_we_ram}, (v.op == 2'b00) ? 32'd1 : 32'd0);
                    chk("strobe_oe", {30'b0, S_oe_ram}, (v.op == 2'b01) ? 32'd1 : 32'd0);
                    chk("strobe_addr", {18'b0, S_addr_ram}, {25'b0, v.addr});
                    chk("strobe_wdata", {16'b0, S_Wdata_ram}, (v.op == 2'b00) ? {24'b0, v.wdata} : 32'd0);
                    chk("strobe_size", {24'b0, S_data_ram_size}, 32'd8);
                end else if (v.op == 2'b10) begin
                    chk("start_pulse", {31'b0, start_port}, 32'd1);
                end
            end
            if (c == 2)
                chk("pulse_one_cycle", {27'b0, start_port, S_we_ram, S_oe_ram}, 32'd0);
            if (host.rsp_valid) begin
                lat = c;
                break;
            end
            Sout_DataRdy = {1'b0, (v.op[1] == 1'b0) && (c == 1 + v.dly)};
            done_port    = (v.op == 2'b10) && (v.dly > 0) && (c == v.dly);
        end
        Sout_DataRdy = 2'b00;
        done_port    = 1'b0;
        chk("rsp_latency", lat, v.exp_lat);
        chk("rsp_data", {24'b0, host.rsp_data}, {24'b0, v.exp_data});
        chk("rsp_status", {30'b0, host.rsp_status}, {30'b0, v.exp_status});
        chk("run_cycles", run_cycles, v.exp_cycles);
    endtask

    // Kernel reset low through the release cycle plus one more, then ready.
    task automatic post_reset_chk();
        @(negedge clock);
        chk("krst_low", {30'b0, kern_reset_n, host.cmd_ready}, 32'd0);
        @(negedge clock);
        chk("krst_done", {30'b0, kern_reset_n, host.cmd_ready}, 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset          = 1'b1;
        host.cmd_valid = 1'b0;
        host.cmd_op    = 2'b00;
        host.cmd_addr  = '0;
        host.cmd_wdata = 8'h00;
        done_port      = 1'b0;
        Sout_Rdata_ram = 16'h0000;
        Sout_DataRdy   = 2'b00;

        //            op     addr   wdata  rdata  dly data   st     cycles lat
        vecs[0] = '{2'b00, 7'h05, 8'hA7, 8'h00, 2, 8'h00, 2'b00, 32'd0, 4};
        vecs[1] = '{2'b01, 7'h05, 8'h00, 8'hA7, 0, 8'hA7, 2'b00, 32'd0, 2};
        vecs[2] = '{2'b01, 7'h7F, 8'h11, 8'h3C, 1, 8'h3C, 2'b00, 32'd0, 3};
        vecs[3] = '{2'b10, 7'h00, 8'h00, 8'h00, 5, 8'h00, 2'b01, 32'd5, 6};
        vecs[4] = '{2'b10, 7'h00, 8'h00, 8'h00, 1, 8'h00, 2'b01, 32'd1, 2};
        vecs[5] = '{2'b11, 7'h22, 8'h33, 8'h00, 0, 8'h00, 2'b00, 32'd1, 1};
        vecs[6] = '{2'b00, 7'h00, 8'hFF, 8'h00, 0, 8'h00, 2'b00, 32'd1, 2};
        vecs[7] = '{2'b10, 7'h00, 8'h00, 8'h00, 3, 8'h00, 2'b01, 32'd3, 4};

        repeat (3) @(negedge clock);
        chk("reset_outs", {24'b0, kern_reset_n, host.cmd_ready, host.rsp_valid, start_port,
                           S_oe_ram, S_we_ram}, 32'd0);
        chk("reset_rsp", {22'b0, host.rsp_data, host.rsp_status}, 32'd0);
        chk("reset_run_cycles", run_cycles, 32'd0);
        chk("reset_s_bus", {S_addr_ram, S_Wdata_ram, 2'b00} | {24'b0, S_data_ram_size}, 32'd0);
        reset = 1'b0;
        post_reset_chk();

        foreach (vecs[i]) run_cmd(vecs[i]);

`ifdef HLS_RUN_TIMEOUT_EN
        v = '{2'b10, 7'h00, 8'h00, 8'h00, 0, 8'h00, 2'b10, 32'd16, 17};
        run_cmd(v);
        @(negedge clock);
        chk("tmo_krst1", {30'b0, kern_reset_n, host.cmd_ready}, 32'd0);
        @(negedge clock);
        chk("tmo_krst2", {30'b0, kern_reset_n, host.cmd_ready}, 32'd0);
        @(negedge clock);
        chk("tmo_ready", {30'b0, kern_reset_n, host.cmd_ready}, 32'd3);
`else
        v = '{2'b10, 7'h00, 8'h00, 8'h00, 20, 8'h00, 2'b01, 32'd20, 21};
        run_cmd(v);
`endif

        // Reset during the write strobe must drop it without a clock edge.
        wait_ready();
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'b00;
        host.cmd_addr  = 7'h44;
        host.cmd_wdata = 8'h99;
        @(posedge clock);
        @(negedge clock);
        host.cmd_valid = 1'b0;
        chk("pre_rst_we", {30'b0, S_we_ram}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_we_drop", {30'b0, S_we_ram}, 32'd0);
        chk("async_addr_drop", {18'b0, S_addr_ram}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        post_reset_chk();

        // Run with done never seen, then reset at count 7.
        wait_ready();
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'b10;
        @(posedge clock);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            host.cmd_valid = 1'b0;
            chk("run_no_rsp", {31'b0, host.rsp_valid}, 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("rst_run_outs", {28'b0, start_port, host.rsp_valid, kern_reset_n, host.cmd_ready}, 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        repeat (2) @(negedge clock);
        chk("rst_hold_no_rsp", {31'b0, host.rsp_valid}, 32'd0);
        reset = 1'b0;
        post_reset_chk();

        v = '{2'b10, 7'h00, 8'h00, 8'h00, 2, 8'h00, 2'b01, 32'd2, 3};
        run_cmd(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
